mux2_rr_arbiter: RTL

//  Round-robin arbiter that shares one 2:1 mux output (in0/in1 -> out0) between two requesters.

---
 rtl/mux2_rr_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter
//   Two-requester round-robin arbiter in front of a shared 2:1 mux.
//   It owns the mux select, the per-requester grants and a registered copy
//   of the muxed data. A grant lasts at most MAX_HOLD cycles while the
//   other side is also requesting, so neither requester can starve.
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req0/req1  requests from side 0 / side 1
//   in0/in1    side 0 / side 1 data (W bits)
//   gnt0/gnt1  registered grants, one-hot or both low
//   sel        registered mux select (0=in0, 1=in1), holds while idle
//   out0       registered muxed data, captured in grant cycles only
//   out_valid  out0 holds the beat captured in the previous grant cycle
module mux2_rr_arbiter #(
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         sel,
  output logic [W-1:0] out0,
  output logic         out_valid
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          last_gnt;   // side that most recently won a grant
  logic          hold_max;   // current owner has used up its turn
  logic          contended;  // the side not holding the grant is requesting

  assign hold_max  = (cnt == CNT_LAST);
  assign contended = ((state == GNT0) && req1) || ((state == GNT1) && req0);

  // State, counter, last-winner, select and data registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last_gnt  <= 1'b1;
      sel       <= 1'b0;
      out0      <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;

      // Counter only advances while the other side is waiting; a lone
      // requester keeps cnt at zero and may hold indefinitely.
      if (state_nxt != state) cnt <= '0;
      else if (contended)     cnt <= cnt + CW'(1);
      else                    cnt <= '0;

      if (state_nxt != state) begin
        if (state_nxt == GNT0) last_gnt <= 1'b0;
        if (state_nxt == GNT1) last_gnt <= 1'b1;
      end

      // sel follows the grant and keeps its last value through IDLE
      if (state_nxt == GNT0)      sel <= 1'b0;
      else if (state_nxt == GNT1) sel <= 1'b1;

      // Data is captured one edge after the grant appears, so a
      // GNT0->GNT1 hand-off yields back-to-back beats with no bubble.
      out_valid <= (state != IDLE);
      if (state != IDLE) out0 <= (state == GNT1) ? in1 : in0;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && req1) state_nxt = last_gnt ? GNT0 : GNT1;
        else if (req0)    state_nxt = GNT0;
        else if (req1)    state_nxt = GNT1;
      end
      GNT0: begin
        if (!req0)                state_nxt = req1 ? GNT1 : IDLE;
        else if (req1 && hold_max) state_nxt = GNT1;
      end
      GNT1: begin
        if (!req1)                state_nxt = req0 ? GNT0 : IDLE;
        else if (req0 && hold_max) state_nxt = GNT0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant outputs decode straight from the state register
  always_comb begin
    gnt0 = (state == GNT0);
    gnt1 = (state == GNT1);
  end

endmodule
